// File: rtl/sw_rst_pkg.sv
// Shared types, default constants and counter-width helpers for the software reset initiator.
package sw_rst_pkg;

    typedef enum logic [2:0] {
        IDLE,
        ASSERT,
        WAIT_ACK,
        WAIT_REL,
        HOLDOFF
    } sw_rst_state_t;

    localparam int unsigned DEF_PULSE_CYCLES   = 16;
    localparam int unsigned DEF_ACK_TIMEOUT    = 1024;
    localparam int unsigned DEF_HOLDOFF_CYCLES = 8;

    // Bits needed to hold the value n (at least one bit).
    function automatic int unsigned cnt_width(input int unsigned n);
        return (n < 1) ? 1 : $clog2(n + 1);
    endfunction

    // The pulse counter must also hold any 8-bit cfg_pulse_len override.
    function automatic int unsigned pulse_cnt_width(input int unsigned n);
        int unsigned w;
        w = cnt_width(n);
        return (w < 8) ? 8 : w;
    endfunction

endpackage

// File: rtl/sw_rst_cnt.sv
// Loadable saturating down-counter with a zero flag; load has priority over decrement.
module sw_rst_cnt #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    input  logic             dec,
    output logic             zero
);

    logic [WIDTH-1:0] count;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count <= '0;
        end else if (load) begin
            count <= load_val;
        end else if (dec && (count != '0)) begin
            count <= count - WIDTH'(1);
        end
    end

    assign zero = (count == '0);

endmodule

// File: rtl/sw_rst_ctrl.sv
// Software reset initiator: stretched assertion, ack/release tracking, holdoff and timeout.
// Build option SW_RST_REQ_QUEUE_EN: a request arriving while busy is held as one pending request.
module sw_rst_ctrl
    import sw_rst_pkg::*;
#(
    parameter int unsigned PULSE_CYCLES   = DEF_PULSE_CYCLES,
    parameter int unsigned ACK_TIMEOUT    = DEF_ACK_TIMEOUT,
    parameter int unsigned HOLDOFF_CYCLES = DEF_HOLDOFF_CYCLES
) (
    input  logic       clk,
    input  logic       hardware_rst,
    input  logic       req,
    input  logic [7:0] cfg_pulse_len,
    input  logic       internal_rst,
    output logic       software_rst,
    output logic       busy,
    output logic       done,
    output logic       timeout_err
);

    localparam int unsigned PW = pulse_cnt_width(PULSE_CYCLES);
    localparam int unsigned TW = cnt_width(ACK_TIMEOUT);
    localparam int unsigned HW = cnt_width(HOLDOFF_CYCLES);

    sw_rst_state_t state, state_d;
    logic sw_d, busy_d, done_d, tmo_d;
    logic ack_seen, ack_d;
    logic start;
    logic p_load, p_dec, p_zero;
    logic t_load, t_dec, t_zero;
    logic h_load, h_dec, h_zero;
    logic [PW-1:0] pulse_len;

`ifdef SW_RST_REQ_QUEUE_EN
    logic pending;

    always_ff @(posedge clk or posedge hardware_rst) begin
        if (hardware_rst) begin
            pending <= 1'b0;
        end else begin
            pending <= (state != IDLE) ? (pending | req) : 1'b0;
        end
    end

    assign start = req | pending;
`else
    assign start = req;
`endif

    assign pulse_len = (cfg_pulse_len == '0) ? PW'(PULSE_CYCLES) : PW'(cfg_pulse_len);

    // Counters are loaded with N-1 so a state lasts exactly N cycles.
    sw_rst_cnt #(.WIDTH(PW)) u_pulse_cnt (
        .clk      (clk),
        .rst      (hardware_rst),
        .load     (p_load),
        .load_val (pulse_len - PW'(1)),
        .dec      (p_dec),
        .zero     (p_zero)
    );

    sw_rst_cnt #(.WIDTH(TW)) u_tmo_cnt (
        .clk      (clk),
        .rst      (hardware_rst),
        .load     (t_load),
        .load_val (TW'(ACK_TIMEOUT - 1)),
        .dec      (t_dec),
        .zero     (t_zero)
    );

    sw_rst_cnt #(.WIDTH(HW)) u_hold_cnt (
        .clk      (clk),
        .rst      (hardware_rst),
        .load     (h_load),
        .load_val (HW'(HOLDOFF_CYCLES - 1)),
        .dec      (h_dec),
        .zero     (h_zero)
    );

    always_ff @(posedge clk or posedge hardware_rst) begin
        if (hardware_rst) begin
            state        <= IDLE;
            software_rst <= 1'b0;
            busy         <= 1'b0;
            done         <= 1'b0;
            timeout_err  <= 1'b0;
            ack_seen     <= 1'b0;
        end else begin
            state        <= state_d;
            software_rst <= sw_d;
            busy         <= busy_d;
            done         <= done_d;
            timeout_err  <= tmo_d;
            ack_seen     <= ack_d;
        end
    end

    always_comb begin
        state_d = state;
        sw_d    = software_rst;
        busy_d  = busy;
        done_d  = 1'b0;
        tmo_d   = timeout_err;
        ack_d   = ack_seen;
        p_load  = 1'b0;
        p_dec   = 1'b0;
        t_load  = 1'b0;
        t_dec   = 1'b0;
        h_load  = 1'b0;
        h_dec   = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    state_d = ASSERT;
                    sw_d    = 1'b1;
                    busy_d  = 1'b1;
                    tmo_d   = 1'b0;
                    ack_d   = 1'b0;
                    p_load  = 1'b1;
                end
            end
            ASSERT: begin
                if (internal_rst) ack_d = 1'b1;
                if (p_zero) begin
                    t_load = 1'b1;
                    if (ack_seen || internal_rst) begin
                        state_d = WAIT_REL;
                        sw_d    = 1'b0;
                    end else begin
                        state_d = WAIT_ACK;
                    end
                end else begin
                    p_dec = 1'b1;
                end
            end
            WAIT_ACK: begin
                t_dec = 1'b1;
                if (internal_rst) begin
                    state_d = WAIT_REL;
                    sw_d    = 1'b0;
                end else if (t_zero) begin
                    state_d = IDLE;
                    sw_d    = 1'b0;
                    busy_d  = 1'b0;
                    tmo_d   = 1'b1;
                end
            end
            WAIT_REL: begin
                t_dec = 1'b1;
                if (!internal_rst) begin
                    state_d = HOLDOFF;
                    h_load  = 1'b1;
                end else if (t_zero) begin
                    state_d = IDLE;
                    busy_d  = 1'b0;
                    tmo_d   = 1'b1;
                end
            end
            HOLDOFF: begin
                if (internal_rst) begin
                    h_load = 1'b1;
                end else if (h_zero) begin
                    state_d = IDLE;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                end else begin
                    h_dec = 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
                sw_d    = 1'b0;
                busy_d  = 1'b0;
            end
        endcase
    end

endmodule

// File: doc/sw_rst_ctrl.md
Name: sw_rst_ctrl

Overview:
Software-reset initiator that drives the `software_rst` input of the reset synchronizer. It watches the synchronized `internal_rst` that comes back, to confirm the reset took effect and was released. It turns a one-cycle register-bank request into a sequence: stretched assertion, acknowledge, release wait, then holdoff. It reports busy, done and timeout to the control/status register bank.

Parameters:
- PULSE_CYCLES, 16: default `software_rst` assertion length in clk cycles, used when `cfg_pulse_len`==0.
- ACK_TIMEOUT, 1024: max cycles spent in WAIT_ACK plus WAIT_REL combined before aborting.
- HOLDOFF_CYCLES, 8: quiet cycles after `internal_rst` release before signalling done.

Ports:
- clk  in  1  system clock
- hardware_rst  in  1  asynchronous, active-high reset
- req  in  1  single-cycle software reset request from register bank
- cfg_pulse_len  in  8  assertion length override; 0 selects PULSE_CYCLES
- internal_rst  in  1  synchronized reset fed back from the reset synchronizer (3-cycle lag)
- software_rst  out  1  registered reset request to the reset synchronizer
- busy  out  1  high whenever state != IDLE
- done  out  1  one-cycle pulse on successful completion
- timeout_err  out  1  sticky error flag

Behaviour:
- Async reset values: state=IDLE, software_rst=0, busy=0, done=0, timeout_err=0, all counters=0, ack_seen=0, pending=0.
- All outputs are registered. FSM states: IDLE, ASSERT, WAIT_ACK, WAIT_REL, HOLDOFF.
- IDLE:
  - req=1 in cycle N -> ASSERT; software_rst=1 and busy=1 from cycle N+1.
  - Latch L = (cfg_pulse_len==0) ? PULSE_CYCLES : cfg_pulse_len.
  - The same req edge clears timeout_err.
- ASSERT:
  - software_rst held high for exactly L cycles.
  - ack_seen set if internal_rst==1 in any ASSERT cycle.
  - At the end of L: if ack_seen -> WAIT_REL with software_rst=0; else -> WAIT_ACK with software_rst still 1.
- WAIT_ACK: software_rst=1; timeout counter runs; internal_rst==1 -> WAIT_REL, drop software_rst next cycle.
- WAIT_REL: software_rst=0; timeout counter continues (not reset between WAIT_ACK and WAIT_REL); internal_rst==0 -> HOLDOFF.
- HOLDOFF: counts HOLDOFF_CYCLES. If internal_rst rises again here, the counter restarts (spurious reset, e.g. hardware path). On expiry -> IDLE; done=1 for one cycle, coincident with busy falling.
- Timeout:
  - Counter reaching ACK_TIMEOUT in WAIT_ACK/WAIT_REL -> IDLE, software_rst=0, timeout_err=1, no done pulse.
  - Counter width is clog2(ACK_TIMEOUT+1) and saturates; it never wraps.
- Counter widths:
  - Pulse counter is 8 bits minimum, widened to hold PULSE_CYCLES.
  - L=1 is legal; with L < 3, the sequence always passes through WAIT_ACK because of the synchronizer lag.
- req while busy: ignored (see Optional Feature).
- req in the same cycle as done returns to IDLE: ignored. A new request is accepted only when busy==0.
- hardware_rst mid-sequence: immediate return to reset values; no done, no error.
- cfg_pulse_len is sampled only on an accepted req; later changes do not affect a running sequence.

Optional Feature:
- Macro SW_RST_REQ_QUEUE_EN.
- Defined: a req while busy sets a single pending flag; further reqs are merged into it. On return to IDLE (done or timeout), a pending request starts a new ASSERT on the next cycle using cfg_pulse_len sampled at that start, and pending clears. hardware_rst clears pending.
- Undefined: the pending logic is absent and req while busy is dropped.

Decomposition:
- Shared package sw_rst_pkg:
  - state enum (IDLE, ASSERT, WAIT_ACK, WAIT_REL, HOLDOFF)
  - default constants for PULSE_CYCLES, ACK_TIMEOUT, HOLDOFF_CYCLES
  - counter-width function
- One natural sub-module, sw_rst_cnt: a loadable down-counter with zero flag, instantiated for the pulse, timeout and holdoff counters.
- The FSM stays in the top module.

Test Plan:
- Nominal: cfg_pulse_len=0, feedback via a real reset synchronizer, req at cycle 10 -> software_rst high cycles 11-26 (16 cycles); internal_rst high ~cycles 14-29; done pulse exactly HOLDOFF_CYCLES cycles after internal_rst falls; busy high from cycle 11 until done.
- Short pulse: cfg_pulse_len=1 -> software_rst high 1 cycle in ASSERT, then held in WAIT_ACK until internal_rst=1; released next cycle; done follows; timeout_err stays 0.
- Timeout: internal_rst tied 0, ACK_TIMEOUT=64 -> software_rst drops and timeout_err=1 after L+64 cycles, no done pulse; next req clears timeout_err.
- Spurious re-assert: internal_rst pulses high in HOLDOFF cycle 4 -> holdoff restarts; done arrives HOLDOFF_CYCLES after that pulse falls.
- Busy collision: req at cycle 10 and 15. Without macro -> exactly one done. With SW_RST_REQ_QUEUE_EN -> two back-to-back sequences, two done pulses.
- Mid-operation reset: hardware_rst asserted during WAIT_ACK -> software_rst, busy, done, timeout_err and pending all 0 immediately (asynchronously); after release, a new req runs a normal sequence.
